// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath.
// The sequencer uses the master view; the datapath (or a bench) uses the slave view.
interface ctrl_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
);
    logic                run;
    logic [31:0]         ir;
    logic                mem_ready;
    logic                PCout, MARin, IncPC, Zin, PCin, Read, MDRin;
    logic                MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic [4:0]          alu_op;
    logic                done;
    logic                illegal;
    logic                halted;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  run, ir, mem_ready,
        output PCout, MARin, IncPC, Zin, PCin, Read, MDRin,
        output MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin,
        output reg_in, reg_out, alu_op, done, illegal, halted, instr_count
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin,
        input  MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin,
        input  reg_in, reg_out, alu_op, done, illegal, halted, instr_count
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for a simple register-file CPU.
// Every strobe is registered: the next-state logic also computes the outputs of the state being entered.
module ctrl_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              clr,
    ctrl_sequencer_if.master bus
);
    localparam int RSEL_W = 4;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    typedef struct packed {
        logic                pcout, marin, incpc, zin, pcin, read, mdrin;
        logic                mdrout, irin, yin, zlowout, zhighout, hiin, loin;
        logic                done, illegal, halted;
        logic [4:0]          alu_op;
        logic [NUM_REGS-1:0] reg_in;
        logic [NUM_REGS-1:0] reg_out;
    } out_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_binary(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
               (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL) ||
               is_muldiv(op);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // Out-of-range register indices match no bit, giving an all-zero vector.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [RSEL_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == RSEL_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    state_t            state_q, state_d;
    out_t              out_q, out_d;
    logic [4:0]        op_q;
    logic [RSEL_W-1:0] ra_q, rc_q;
    logic [CNT_W-1:0]  count_q;
    state_t            end_state;

    logic [4:0]        ir_op;
    logic [RSEL_W-1:0] ir_ra, ir_rb, ir_rc;
    logic              unused_ir;

    assign ir_op     = bus.ir[31:27];
    assign ir_ra     = bus.ir[26:23];
    assign ir_rb     = bus.ir[22:19];
    assign ir_rc     = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];
    assign end_state = bus.run ? T0 : IDLE;

    always_comb begin
        state_d = state_q;
        out_d   = '0;

        case (state_q)
            IDLE:    if (bus.run) state_d = T0;
            T0:      state_d = T1;
            T1:      if (bus.mem_ready) state_d = T2;
            T2:      state_d = T3;
            T3: begin
                if (is_binary(op_q) || is_unary(op_q)) state_d = T4;
                else if (op_q == OP_HALT)              state_d = HALT;
                else                                   state_d = end_state;
            end
            T4:      state_d = is_binary(op_q) ? T5 : end_state;
            T5:      state_d = is_muldiv(op_q) ? T6 : end_state;
            T6:      state_d = end_state;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Outputs of the state being entered. T3 is only reached from T2, so it decodes ir directly.
        case (state_d)
            T0: begin
                out_d.pcout = 1'b1;
                out_d.marin = 1'b1;
                out_d.incpc = 1'b1;
                out_d.zin   = 1'b1;
            end
            T1: begin
                out_d.zlowout = 1'b1;
                out_d.pcin    = (state_q == T0);
                out_d.read    = 1'b1;
                out_d.mdrin   = 1'b1;
            end
            T2: begin
                out_d.mdrout = 1'b1;
                out_d.irin   = 1'b1;
            end
            T3: begin
                if (is_binary(ir_op)) begin
                    out_d.reg_out = onehot(ir_rb);
                    out_d.yin     = 1'b1;
                end else if (is_unary(ir_op)) begin
                    out_d.reg_out = onehot(ir_rb);
                    out_d.alu_op  = ir_op;
                    out_d.zin     = 1'b1;
                end else if (ir_op != OP_HALT) begin
                    out_d.illegal = 1'b1;
                end
            end
            T4: begin
                if (is_binary(op_q)) begin
                    out_d.reg_out = onehot(rc_q);
                    out_d.alu_op  = op_q;
                    out_d.zin     = 1'b1;
                end else begin
                    out_d.zlowout = 1'b1;
                    out_d.reg_in  = onehot(ra_q);
                    out_d.done    = 1'b1;
                end
            end
            T5: begin
                out_d.zlowout = 1'b1;
                if (is_muldiv(op_q)) begin
                    out_d.loin = 1'b1;
                end else begin
                    out_d.reg_in = onehot(ra_q);
                    out_d.done   = 1'b1;
                end
            end
            T6: begin
                out_d.zhighout = 1'b1;
                out_d.hiin     = 1'b1;
                out_d.done     = 1'b1;
            end
            HALT:    out_d.halted = 1'b1;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            out_q   <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (state_q == T2) begin
                op_q <= ir_op;
                ra_q <= ir_ra;
                rc_q <= ir_rc;
            end
            if (out_q.done) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.PCout       = out_q.pcout;
    assign bus.MARin       = out_q.marin;
    assign bus.IncPC       = out_q.incpc;
    assign bus.Zin         = out_q.zin;
    assign bus.PCin        = out_q.pcin;
    assign bus.Read        = out_q.read;
    assign bus.MDRin       = out_q.mdrin;
    assign bus.MDRout      = out_q.mdrout;
    assign bus.IRin        = out_q.irin;
    assign bus.Yin         = out_q.yin;
    assign bus.Zlowout     = out_q.zlowout;
    assign bus.Zhighout    = out_q.zhighout;
    assign bus.HIin        = out_q.hiin;
    assign bus.LOin        = out_q.loin;
    assign bus.reg_in      = out_q.reg_in;
    assign bus.reg_out     = out_q.reg_out;
    assign bus.alu_op      = out_q.alu_op;
    assign bus.done        = out_q.done;
    assign bus.illegal     = out_q.illegal;
    assign bus.halted      = out_q.halted;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a per-cycle vector table plus hand-written reset/halt/width sequences.
// A second instance (8 registers, 2-bit counter) sees the same stimulus.
module tb_ctrl_sequencer;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.NUM_REGS(16), .CNT_W(16)) bus ();
    ctrl_sequencer_if #(.NUM_REGS(8), .CNT_W(2)) bus2 ();

    ctrl_sequencer #(.NUM_REGS(16), .CNT_W(16)) dut (.clk(clk), .clr(clr), .bus(bus));
    ctrl_sequencer #(.NUM_REGS(8), .CNT_W(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

    assign bus2.run       = bus.run;
    assign bus2.ir        = bus.ir;
    assign bus2.mem_ready = bus.mem_ready;

    localparam logic [13:0] PCOUT = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800, ZIN = 14'h0400;
    localparam logic [13:0] PCIN = 14'h0200, READ = 14'h0100, MDRIN = 14'h0080, MDROUT = 14'h0040;
    localparam logic [13:0] IRIN = 14'h0020, YIN = 14'h0010, ZLO = 14'h0008, ZHI = 14'h0004;
    localparam logic [13:0] HIIN = 14'h0002, LOIN = 14'h0001;
    localparam logic [13:0] T0S = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [13:0] T1F = ZLO | PCIN | READ | MDRIN;
    localparam logic [13:0] T1S = ZLO | READ | MDRIN;
    localparam logic [13:0] T2S = MDROUT | IRIN;

    logic [13:0] obs_s;
    logic [2:0]  obs_f;
    assign obs_s = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.PCin, bus.Read, bus.MDRin,
                    bus.MDRout, bus.IRin, bus.Yin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin};
    assign obs_f = {bus.halted, bus.illegal, bus.done};

    typedef struct {
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [13:0] s;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic [2:0]  f;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic run, input logic mr, input logic [31:0] ir, input logic [13:0] s,
                       input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu,
                       input logic [2:0] f, input logic [15:0] cnt);
        vec_t v;
        v.run = run; v.mr = mr; v.ir = ir; v.s = s; v.rin = rin;
        v.rout = rout; v.alu = alu; v.f = f; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.done && n < 20);
        chk({nm, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_strobes"}, 32'(obs_s), 32'd0);
        chk({nm, "_flags"}, 32'(obs_f), 32'd0);
        chk({nm, "_reg_in"}, 32'(bus.reg_in), 32'd0);
        chk({nm, "_reg_out"}, 32'(bus.reg_out), 32'd0);
        chk({nm, "_alu"}, 32'(bus.alu_op), 32'd0);
        chk({nm, "_count"}, 32'(bus.instr_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] i_and, i_mul, i_neg, i_ill, i_halt, i_not;
        logic [1:0]  exp2 [5];
        i_and  = 32'h2891_8000;
        i_mul  = mk(5'b01111, 4'd4, 4'd5, 4'd6);
        i_neg  = mk(5'b10001, 4'd7, 4'd9, 4'd0);
        i_ill  = mk(5'b11111, 4'd1, 4'd2, 4'd3);
        i_halt = mk(5'b11011, 4'd0, 4'd0, 4'd0);
        i_not  = mk(5'b10010, 4'd12, 4'd3, 4'd0);
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd0; exp2[4] = 2'd1;

        // AND r1 = r2 & r3: six cycles T0..T5
        add(1, 1, i_and, T0S, 0, 0, 0, 0, 0);
        add(1, 1, i_and, T1F, 0, 0, 0, 0, 0);
        add(1, 1, i_and, T2S, 0, 0, 0, 0, 0);
        add(1, 1, i_and, YIN, 0, 16'h0004, 0, 0, 0);
        add(1, 1, i_and, ZIN, 0, 16'h0008, 5'b00101, 0, 0);
        add(1, 1, i_and, ZLO, 16'h0002, 0, 0, 3'b001, 0);
        add(0, 1, i_and, 0, 0, 0, 0, 0, 1);
        // MUL Ra=4: seven cycles, no register write
        add(1, 1, i_mul, T0S, 0, 0, 0, 0, 1);
        add(1, 1, i_mul, T1F, 0, 0, 0, 0, 1);
        add(1, 1, i_mul, T2S, 0, 0, 0, 0, 1);
        add(1, 1, i_mul, YIN, 0, 16'h0020, 0, 0, 1);
        add(1, 1, i_mul, ZIN, 0, 16'h0040, 5'b01111, 0, 1);
        add(1, 1, i_mul, ZLO | LOIN, 0, 0, 0, 0, 1);
        add(1, 1, i_mul, ZHI | HIIN, 0, 0, 0, 3'b001, 1);
        add(0, 1, i_mul, 0, 0, 0, 0, 0, 2);
        // NEG r7 = -r9: five cycles
        add(1, 1, i_neg, T0S, 0, 0, 0, 0, 2);
        add(1, 1, i_neg, T1F, 0, 0, 0, 0, 2);
        add(1, 1, i_neg, T2S, 0, 0, 0, 0, 2);
        add(1, 1, i_neg, ZIN, 0, 16'h0200, 5'b10001, 0, 2);
        add(1, 1, i_neg, ZLO, 16'h0080, 0, 0, 3'b001, 2);
        add(0, 1, i_neg, 0, 0, 0, 0, 0, 3);
        // AND with mem_ready low for three T1 cycles
        add(1, 0, i_and, T0S, 0, 0, 0, 0, 3);
        add(1, 0, i_and, T1F, 0, 0, 0, 0, 3);
        add(1, 0, i_and, T1S, 0, 0, 0, 0, 3);
        add(1, 0, i_and, T1S, 0, 0, 0, 0, 3);
        add(1, 0, i_and, T1S, 0, 0, 0, 0, 3);
        add(1, 1, i_and, T2S, 0, 0, 0, 0, 3);
        add(1, 1, i_and, YIN, 0, 16'h0004, 0, 0, 3);
        add(1, 1, i_and, ZIN, 0, 16'h0008, 5'b00101, 0, 3);
        add(1, 1, i_and, ZLO, 16'h0002, 0, 0, 3'b001, 3);
        add(0, 1, i_and, 0, 0, 0, 0, 0, 4);
        // Illegal opcode twice: run=1 restarts at T0, run=0 returns to IDLE
        add(1, 1, i_ill, T0S, 0, 0, 0, 0, 4);
        add(1, 1, i_ill, T1F, 0, 0, 0, 0, 4);
        add(1, 1, i_ill, T2S, 0, 0, 0, 0, 4);
        add(1, 1, i_ill, 0, 0, 0, 0, 3'b010, 4);
        add(1, 1, i_ill, T0S, 0, 0, 0, 0, 4);
        add(1, 1, i_ill, T1F, 0, 0, 0, 0, 4);
        add(1, 1, i_ill, T2S, 0, 0, 0, 0, 4);
        add(0, 1, i_ill, 0, 0, 0, 0, 3'b010, 4);
        add(0, 1, i_ill, 0, 0, 0, 0, 0, 4);

        clr = 1'b0;
        bus.run = 1'b0;
        bus.ir = '0;
        bus.mem_ready = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        clr = 1'b1;
        step();
        chk("idle_strobes", 32'(obs_s), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.run = tbl[i].run;
            bus.mem_ready = tbl[i].mr;
            bus.ir = tbl[i].ir;
            step();
            chk($sformatf("row%0d_strobes", i), 32'(obs_s), 32'(tbl[i].s));
            chk($sformatf("row%0d_reg_in", i), 32'(bus.reg_in), 32'(tbl[i].rin));
            chk($sformatf("row%0d_reg_out", i), 32'(bus.reg_out), 32'(tbl[i].rout));
            chk($sformatf("row%0d_alu", i), 32'(bus.alu_op), 32'(tbl[i].alu));
            chk($sformatf("row%0d_flags", i), 32'(obs_f), 32'(tbl[i].f));
            chk($sformatf("row%0d_count", i), 32'(bus.instr_count), 32'(tbl[i].cnt));
        end

        // Asynchronous reset in the middle of T4
        bus.run = 1'b1;
        bus.ir = i_and;
        bus.mem_ready = 1'b1;
        repeat (5) step();
        chk("midT4_before", 32'(obs_s), 32'(ZIN));
        #2 clr = 1'b0;
        #1 chk_all_zero("midT4_async");
        #2 clr = 1'b1;
        step();
        chk("midT4_restart", 32'(obs_s), 32'(T0S));
        bus.run = 1'b0;
        wait_done("midT4");
        step();
        chk("midT4_count", 32'(bus.instr_count), 32'd1);

        // HALT holds until reset even with run=1
        bus.run = 1'b1;
        bus.ir = i_halt;
        repeat (4) step();
        chk("halt_T3_flags", 32'(obs_f), 32'd0);
        chk("halt_T3_strobes", 32'(obs_s), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("halt_hold%0d_flags", k), 32'(obs_f), 32'b100);
            chk($sformatf("halt_hold%0d_strobes", k), 32'(obs_s), 32'd0);
            chk($sformatf("halt_hold%0d_count", k), 32'(bus.instr_count), 32'd1);
        end
        #2 clr = 1'b0;
        #1 chk("halt_clr_halted", 32'(bus.halted), 32'd0);
        clr = 1'b1;
        bus.run = 1'b0;
        step();
        chk("halt_after_idle", 32'(obs_s), 32'd0);
        chk("halt_after_flags", 32'(obs_f), 32'd0);

        // NOT r12 = ~r3 on the 8-register instance: reg 12 is out of range there
        bus.run = 1'b1;
        bus.ir = i_not;
        repeat (4) step();
        chk("nregs_T3_rout16", 32'(bus.reg_out), 32'h0008);
        chk("nregs_T3_rout8", 32'(bus2.reg_out), 32'h08);
        bus.run = 1'b0;
        step();
        chk("nregs_T4_rin16", 32'(bus.reg_in), 32'h1000);
        chk("nregs_T4_rin8", 32'(bus2.reg_in), 32'h00);
        chk("nregs_T4_done8", 32'(bus2.done), 32'd1);
        step();

        // 2-bit counter wraps: 1,2,3,0,1
        #2 clr = 1'b0;
        #2 clr = 1'b1;
        bus.run = 1'b1;
        bus.ir = i_and;
        for (int k = 0; k < 5; k++) begin
            wait_done($sformatf("wrap%0d", k));
            if (k == 4) bus.run = 1'b0;
            step();
            chk($sformatf("wrap%0d_cnt2", k), 32'(bus2.instr_count), 32'(exp2[k]));
            chk($sformatf("wrap%0d_cnt16", k), 32'(bus.instr_count), 32'(k + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
